// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter FSM encoding and parity-type codes.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } arb_state_t;

  localparam int DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr,
// wrapping around. Purely combinational.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Scan from ptr upward, modulo N, and keep the first hit.
  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among
// N_REQ byte requesters; tracks busy to delimit each frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*8-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_par_en,
  input  logic [N_REQ-1:0]           req_par_type,
  output logic [N_REQ-1:0]           req_ready,
  output logic [7:0]                 p_data,
  output logic                       data_valid,
  output logic                       par_en,
  output logic                       par_type,
  input  logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       frame_done,
  output logic                       start_err
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t     state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  ptr_next;
  logic [3:0]     cnt;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic           grant;

  uart_rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grant only from IDLE while the transmitter is quiet.
  always_comb begin
    grant     = (state == IDLE) && !busy && pick_any;
    req_ready = grant ? pick_oh : '0;
  end

  // Pointer moves to the slot just after the last winner.
  always_comb begin
    if (grant_id == IW'(N_REQ - 1))
      ptr_next = '0;
    else
      ptr_next = grant_id + 1'b1;
  end

  // Main FSM with registered transmitter-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      grant_id   <= '0;
      p_data     <= '0;
      par_en     <= 1'b0;
      par_type   <= PAR_EVEN;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      start_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            p_data     <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            par_en     <= req_par_en[pick_idx];
            par_type   <= req_par_type[pick_idx];
            grant_id   <= pick_idx;
            data_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (busy) begin
            state <= WAIT_DONE;
          end else if (cnt + 4'd1 == 4'(START_TO)) begin
            start_err <= 1'b1;
            ptr       <= ptr_next;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!busy) begin
            frame_done <= 1'b1;
            ptr        <= ptr_next;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
